// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RISC-V style control FSM with memory-wait timeout trap.
// Outputs are decoded from the state register and forced low while reset is held.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       trap
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
        WB = 3'd4, BRANCH = 3'd5, TRAP = 3'd6, ILLEGAL = 3'd7
    } state_t;
    typedef enum logic [2:0] {C_NONE, C_R, C_I, C_LW, C_SW, C_BEQ} cls_t;
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_src;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       done;
        logic       trap;
    } ctl_t;

    state_t     cur, nxt;
    cls_t       cls, dec_cls;
    ctl_t       c;
    logic [7:0] cnt;
    logic       timeout;

    assign timeout = !mem_ready && (cnt == 8'(MEM_TIMEOUT - 1));
    assign dec_cls = (Opcode == 7'b0110011) ? C_R   :
                     (Opcode == 7'b0010011) ? C_I   :
                     (Opcode == 7'b0000011) ? C_LW  :
                     (Opcode == 7'b0100011) ? C_SW  :
                     (Opcode == 7'b1100011) ? C_BEQ : C_NONE;

    always_comb begin
        c   = '0;
        nxt = cur;
        case (cur)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
                nxt = mem_ready ? DECODE : timeout ? TRAP : FETCH;
            end
            DECODE: begin
                c.alu_src_b = 2'b10;
                nxt = (dec_cls == C_BEQ) ? BRANCH : (dec_cls == C_NONE) ? TRAP : EXEC;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = (cls == C_R) ? 2'b00 : 2'b10;
                c.alu_op    = (cls == C_R) ? 2'b10 : (cls == C_I) ? 2'b11 : 2'b00;
                nxt = (cls == C_R || cls == C_I)   ? WB  :
                      (cls == C_LW || cls == C_SW) ? MEM : TRAP;
            end
            MEM: begin
                c.iord      = 1'b1;
                c.mem_read  = (cls == C_LW);
                c.mem_write = (cls == C_SW);
                c.done      = mem_ready && (cls == C_SW);
                nxt = mem_ready ? ((cls == C_LW) ? WB : FETCH) : timeout ? TRAP : MEM;
            end
            WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = (cls == C_LW);
                c.done       = 1'b1;
                nxt = FETCH;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 1'b1;
                c.pc_write  = Zero;
                c.done      = 1'b1;
                nxt = FETCH;
            end
            TRAP: begin
                c.trap = 1'b1;
                nxt = TRAP;
            end
            default: nxt = TRAP;
        endcase
    end

    // The wait counter only runs while lingering in FETCH/MEM; any transition restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= FETCH;
            cls <= C_NONE;
            cnt <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE) cls <= dec_cls;
            cnt <= (nxt != cur || !(cur == FETCH || cur == MEM)) ? 8'd0 :
                   (!mem_ready && cnt != 8'(MEM_TIMEOUT)) ? cnt + 8'd1 : cnt;
        end
    end

    assign {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite,
            ALUSrcA, PCSrc, ALUSrcB, ALUOp, instr_done, trap} = reset ? '0 : c;
    assign state = cur;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
// Control vector bit order: PCWrite IRWrite IorD MemRead MemWrite MemtoReg RegWrite ALUSrcA PCSrc ALUSrcB ALUOp instr_done trap.
module tb_multicycle_ctrl;
    logic       clk = 1'b0, reset = 1'b1, Zero = 1'b0, mem_ready = 1'b1;
    logic [6:0] Opcode = 7'b0110011;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA, PCSrc;
    logic [1:0] ALUSrcB, ALUOp;
    logic [2:0] state;
    logic       instr_done, trap;
    int         checks = 0, failures = 0;

    localparam logic [14:0] ZERO_V = 15'b000000000000000;
    localparam logic [14:0] F_WAIT = 15'b000100000010000;
    localparam logic [14:0] F_GO   = 15'b110100000010000;
    localparam logic [14:0] DEC    = 15'b000000000100000;
    localparam logic [14:0] EX_R   = 15'b000000010001000;
    localparam logic [14:0] EX_I   = 15'b000000010101100;
    localparam logic [14:0] EX_M   = 15'b000000010100000;
    localparam logic [14:0] MEM_LW = 15'b001100000000000;
    localparam logic [14:0] SW_WT  = 15'b001010000000000;
    localparam logic [14:0] SW_DN  = 15'b001010000000010;
    localparam logic [14:0] WB_R   = 15'b000000100000010;
    localparam logic [14:0] WB_LW  = 15'b000001100000010;
    localparam logic [14:0] BR_Z1  = 15'b100000011000110;
    localparam logic [14:0] BR_Z0  = 15'b000000011000110;
    localparam logic [14:0] TRAPV  = 15'b000000000000001;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state),
        .instr_done(instr_done), .trap(trap)
    );

    always #5 clk = ~clk;

    wire [14:0] ctl = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite,
                       ALUSrcA, PCSrc, ALUSrcB, ALUOp, instr_done, trap};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic exp(input string tag, input logic [2:0] st, input logic [14:0] v);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl), 32'(v));
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #3;
        exp("reset_async", 3'd0, ZERO_V);
        cyc; cyc;
        exp("reset_held", 3'd0, ZERO_V);
        mem_ready = 1'b0;
        reset = 1'b0;
        exp("post_reset_fetch", 3'd0, F_WAIT);
        // R-type
        mem_ready = 1'b1;
        exp("r_fetch", 3'd0, F_GO);
        cyc; exp("r_decode", 3'd1, DEC);
        cyc; exp("r_exec", 3'd2, EX_R);
        cyc; exp("r_wb", 3'd4, WB_R);
        cyc;
        // LW with three wait cycles; Opcode scrambled after decode
        Opcode = 7'b0000011;
        exp("lw_fetch", 3'd0, F_GO);
        cyc; exp("lw_decode", 3'd1, DEC);
        cyc; Opcode = 7'b1111111; exp("lw_exec", 3'd2, EX_M);
        cyc; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp("lw_mem_wait", 3'd3, MEM_LW);
            cyc;
        end
        mem_ready = 1'b1;
        exp("lw_mem_done", 3'd3, MEM_LW);
        cyc; exp("lw_wb", 3'd4, WB_LW);
        cyc;
        // SW
        Opcode = 7'b0100011;
        exp("sw_fetch", 3'd0, F_GO);
        cyc; exp("sw_decode", 3'd1, DEC);
        cyc; exp("sw_exec", 3'd2, EX_M);
        cyc; exp("sw_mem", 3'd3, SW_DN);
        cyc; mem_ready = 1'b0; exp("sw_back_fetch", 3'd0, F_WAIT);
        // BEQ taken then not taken
        mem_ready = 1'b1; Opcode = 7'b1100011; Zero = 1'b1;
        cyc; cyc; exp("beq1_branch", 3'd5, BR_Z1);
        Zero = 1'b0; exp("beq1_zero_comb", 3'd5, BR_Z0);
        Zero = 1'b1;
        cyc; Zero = 1'b0;
        cyc; cyc; exp("beq0_branch", 3'd5, BR_Z0);
        cyc;
        // I-type, fetch ready exactly on the 16th waiting cycle
        Opcode = 7'b0010011; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) cyc;
        exp("limit_fetch_wait", 3'd0, F_WAIT);
        mem_ready = 1'b1;
        exp("limit_fetch_go", 3'd0, F_GO);
        cyc; exp("limit_decode", 3'd1, DEC);
        cyc; exp("i_exec", 3'd2, EX_I);
        cyc; exp("i_wb", 3'd4, WB_R);
        cyc;
        // fetch timeout: 16 waiting cycles then TRAP
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1; chk("to_fetch_state", 32'(state), 32'd0);
            cyc;
        end
        exp("to_trap", 3'd6, TRAPV);
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc;
        exp("to_trap_sticky", 3'd6, TRAPV);
        // illegal opcode -> TRAP held 20 cycles
        reset = 1'b1; #1;
        exp("reset_from_trap", 3'd0, ZERO_V);
        cyc; reset = 1'b0; Opcode = 7'b1111111;
        cyc; exp("ill_decode", 3'd1, DEC);
        cyc;
        for (int i = 0; i < 20; i++) begin
            #1; chk("ill_trap_state", 32'(state), 32'd6);
            chk("ill_trap_ctl", 32'(ctl), 32'(TRAPV));
            cyc;
        end
        // reset during SW memory access
        reset = 1'b1; cyc; reset = 1'b0; Opcode = 7'b0100011;
        cyc; cyc; mem_ready = 1'b0;
        cyc; exp("sw_abort_mem", 3'd3, SW_WT);
        #2; reset = 1'b1;
        exp("sw_abort_now", 3'd0, ZERO_V);
        cyc; exp("sw_abort_held", 3'd0, ZERO_V);
        reset = 1'b0;
        exp("sw_abort_fetch", 3'd0, F_WAIT);
        cyc; exp("sw_abort_fetch2", 3'd0, F_WAIT);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
